// File: rtl/pm_byte_loader.sv
// Program-memory write master: packs a little-endian byte stream into instruction words.
// Optional trailing XOR checksum byte when PM_LOADER_CKSUM_EN is defined.
module pm_byte_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 7,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADD_WIDTH-1:0]  base_addr,
  input  logic [ADD_WIDTH:0]    word_len,
  input  logic [WIDTH-1:0]      byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  pmWrEn,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] instructionIn,
  output logic                  busy,
  output logic                  done,
  output logic                  cksum_err
);

  localparam int BEATS = DATA_WIDTH / WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADD_WIDTH:0] ONE_LEFT = (ADD_WIDTH + 1)'(1);

`ifdef PM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CKSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

  state_t                 state;
  logic [ADD_WIDTH-1:0]   addr;
  logic [ADD_WIDTH:0]     remaining;
  logic [BW-1:0]          beat;
  logic [DATA_WIDTH-1:0]  word;
  logic [DATA_WIDTH-1:0]  next_word;
  logic                   accept;

  assign accept = byte_valid && byte_ready;

  // New bytes enter at the top, so after BEATS shifts the first byte sits in the LSB.
  generate
    if (BEATS > 1) begin : g_shift
      assign next_word = {byte_in, word[DATA_WIDTH-1:WIDTH]};
    end else begin : g_single
      assign next_word = byte_in;
    end
  endgenerate

`ifdef PM_LOADER_CKSUM_EN
  logic [WIDTH-1:0] xor_acc;
  logic             cksum_flag;
  assign cksum_err = cksum_flag;
`else
  assign cksum_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      beat          <= '0;
      word          <= '0;
      byte_ready    <= 1'b0;
      pmWrEn        <= 1'b0;
      pm_addr       <= '0;
      instructionIn <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef PM_LOADER_CKSUM_EN
      xor_acc       <= '0;
      cksum_flag    <= 1'b0;
`endif
    end else begin
      pmWrEn <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= word_len;
            beat      <= '0;
            word      <= '0;
`ifdef PM_LOADER_CKSUM_EN
            xor_acc    <= '0;
            cksum_flag <= 1'b0;
`endif
            if (word_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= COLLECT;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (accept) begin
            word <= next_word;
`ifdef PM_LOADER_CKSUM_EN
            xor_acc <= xor_acc ^ byte_in;
`endif
            // Last beat goes straight to the write port so WRITE follows with no bubble.
            if (beat == LAST_BEAT) begin
              beat          <= '0;
              state         <= WRITE;
              byte_ready    <= 1'b0;
              pmWrEn        <= 1'b1;
              pm_addr       <= addr;
              instructionIn <= next_word;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end

        WRITE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == ONE_LEFT) begin
`ifdef PM_LOADER_CKSUM_EN
            state      <= CKSUM;
            byte_ready <= 1'b1;
`else
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
`endif
          end else begin
            state      <= COLLECT;
            byte_ready <= 1'b1;
          end
        end

`ifdef PM_LOADER_CKSUM_EN
        CKSUM: begin
          if (accept) begin
            if (byte_in != xor_acc) cksum_flag <= 1'b1;
            state      <= DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            byte_ready <= 1'b0;
          end
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pm_byte_loader.sv
// Scoreboard bench for pm_byte_loader: expected writes are queued by the stimulus and
// popped by a monitor whenever pmWrEn is seen. Builds with or without PM_LOADER_CKSUM_EN.
module tb_pm_byte_loader;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_len;
  logic [W-1:0]  byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          pmWrEn;
  logic [AW-1:0] pm_addr;
  logic [DW-1:0] instructionIn;
  logic          busy;
  logic          done;
  logic          cksum_err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t expQ[$];
  wr_t monEntry;
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  pm_byte_loader #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_len(word_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .pmWrEn(pmWrEn), .pm_addr(pm_addr), .instructionIn(instructionIn),
    .busy(busy), .done(done), .cksum_err(cksum_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic pushExp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  // Every write the DUT makes must match the head of the scoreboard.
  always @(negedge clk) begin
    if (pmWrEn) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", pmWrEn, 1'b0);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("wr_addr", pm_addr, monEntry.addr);
        checkOutput("wr_data", instructionIn, monEntry.data);
        checkOutput("ready_in_write", byte_ready, 1'b0);
      end
    end
  end

  task automatic startLoad(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1;
    base_addr = b;
    word_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [W-1:0] b, input int gap);
    int waitCnt;
    waitCnt = 0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!byte_ready) checkOutput("ready_timeout", byte_ready, 1'b1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  // Bytes are taken from stream[i*8 +: 8] in order; expected writes are queued by the caller.
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len,
                               input logic [95:0] stream, input bit gaps,
                               input logic [W-1:0] ck, input logic expErr);
    int nBytes;
    nBytes = int'(len) * 4;
    $display("[TB] load base=%0d len=%0d ck=%02h", base, len, ck);
    startLoad(base, len);
    if (len != 0) checkOutput("busy_after_start", busy, 1'b1);
    for (int i = 0; i < nBytes; i++) begin
      sendByte(stream[i*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
      if (i % 4 == 3) checkOutput("write_latency", pmWrEn, 1'b1);
    end
`ifdef PM_LOADER_CKSUM_EN
    if (len != 0) sendByte(ck, 0);
`else
    if (len != 0) begin @(posedge clk); #1; end
`endif
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("busy_at_done", busy, 1'b0);
    checkOutput("cksum_err", cksum_err, expErr);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", done, 1'b0);
    checkOutput("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_len = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pmWrEn", pmWrEn, 1'b0);
    checkOutput("rst_pm_addr", pm_addr, '0);
    checkOutput("rst_instr", instructionIn, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_ready", byte_ready, 1'b0);
    checkOutput("rst_cksum", cksum_err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word, valid held high.
    pushExp(7'd0, 32'h00000013);
    applyStimulus(7'd0, 8'd1, 96'h00000013, 1'b0, 8'h13, 1'b0);

    // Three words with random valid gaps.
    pushExp(7'd5, 32'h44332211);
    pushExp(7'd6, 32'h88776655);
    pushExp(7'd7, 32'h67452301);
    applyStimulus(7'd5, 8'd3, 96'h67452301_88776655_44332211, 1'b1, 8'h88, 1'b0);

    // Address wrap from 127 to 0.
    pushExp(7'd127, 32'h12345678);
    pushExp(7'd0,   32'hDEADBEEF);
    applyStimulus(7'd127, 8'd2, 96'hDEADBEEF_12345678, 1'b0, 8'h2A, 1'b0);

    // Reset partway through the second word.
    pushExp(7'd10, 32'hDDCCBBAA);
    startLoad(7'd10, 8'd3);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    sendByte(8'hCC, 1);
    sendByte(8'hDD, 0);
    sendByte(8'hEE, 0);
    sendByte(8'hFF, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_pmWrEn", pmWrEn, 1'b0);
    checkOutput("abort_pm_addr", pm_addr, '0);
    checkOutput("abort_instr", instructionIn, '0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ready", byte_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("abort_queue", expQ.size(), 0);
    pushExp(7'd10, 32'h01020304);
    applyStimulus(7'd10, 8'd1, 96'h01020304, 1'b0, 8'h04, 1'b0);

    // Start while busy, and start coinciding with the done pulse, are both ignored.
    pushExp(7'd20, 32'h04030201);
    startLoad(7'd20, 8'd1);
    sendByte(8'h01, 0);
    sendByte(8'h02, 0);
    startLoad(7'd50, 8'd2);
    checkOutput("busy_ignore_start", busy, 1'b1);
    sendByte(8'h03, 0);
    sendByte(8'h04, 0);
    checkOutput("write_latency", pmWrEn, 1'b1);
`ifdef PM_LOADER_CKSUM_EN
    sendByte(8'h04, 0);
`else
    @(posedge clk); #1;
`endif
    checkOutput("done_pulse", done, 1'b1);
    startLoad(7'd60, 8'd1);
    checkOutput("start_at_done_done", done, 1'b0);
    checkOutput("start_at_done_busy", busy, 1'b0);
    checkOutput("start_at_done_ready", byte_ready, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("still_idle", busy, 1'b0);

    // Zero-length load: done pulse, no writes.
    applyStimulus(7'd30, 8'd0, 96'h0, 1'b0, 8'h00, 1'b0);

`ifdef PM_LOADER_CKSUM_EN
    pushExp(7'd40, 32'h04030201);
    applyStimulus(7'd40, 8'd1, 96'h04030201, 1'b0, 8'h04, 1'b0);
    pushExp(7'd40, 32'h04030201);
    applyStimulus(7'd40, 8'd1, 96'h04030201, 1'b0, 8'h05, 1'b1);
`endif

    repeat (3) begin @(posedge clk); #1; end
    checkOutput("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
